// File: rtl/link_pkg.sv
// Shared definitions for the toggle-scrambled serial link receiver.
package link_pkg;

  localparam int BYTE_W = 8;

  // Default frame delimiter; its complement marks the opposite transmit phase.
  localparam logic [BYTE_W-1:0] SYNC_WORD_DEF = 8'hB4;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } rx_state_e;

endpackage

// File: rtl/toggle_sync_hunter.sv
// Local phase generator and sync-word window for the toggle-scrambled link.
// The raw bit is the line with the local phase removed; whether the local
// phase agrees with the transmitter is decided later from which form of the
// sync word (true or complemented) shows up in the window.
module toggle_sync_hunter
  import link_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic raw_o,
  output logic match_o,
  output logic match_inv_o
);

  logic              ph_q, ph_d;
  logic [BYTE_W-1:0] sr_q, sr_d;
  logic [BYTE_W-1:0] win;

  // Strip local phase, form the 8-bit window and compare both sync polarities
  always_comb begin
    raw_o       = line_i ^ ph_q;
    win         = {sr_q[BYTE_W-2:0], raw_o};
    ph_d        = ~ph_q;
    sr_d        = win;
    match_o     = (win == SYNC_WORD);
    match_inv_o = (win == ~SYNC_WORD);
  end

  // Phase toggles and the shift register shifts every cycle, in every state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q <= 1'b0;
      sr_q <= '0;
    end else begin
      ph_q <= ph_d;
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/toggle_descrambler_rx.sv
// Receive end of the toggle-scrambled serial link: locks onto the sync word
// (either transmit phase), descrambles the payload and emits one byte per
// 8 bits with a one-cycle valid pulse and an end-of-frame pulse.
module toggle_descrambler_rx
  import link_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD     = SYNC_WORD_DEF,
  parameter int unsigned       PAYLOAD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_done,
  output logic              locked
);

  localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

  rx_state_e         state_q, state_d;
  logic              sel_q, sel_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        byte_q, byte_d;
  logic [BYTE_W-1:0] deser_q, deser_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic raw, match, match_inv;
  logic dbit, byte_end, frame_end;

  toggle_sync_hunter #(
    .SYNC_WORD (SYNC_WORD)
  ) u_hunter (
    .clk_i       (clk),
    .rst_i       (rst),
    .line_i      (line_in),
    .raw_o       (raw),
    .match_o     (match),
    .match_inv_o (match_inv)
  );

  // Descrambled payload bit and byte/frame boundary qualifiers
  always_comb begin
    dbit      = raw ^ sel_q;
    byte_end  = (state_q == PAYLOAD) && (bit_q == 3'd7);
    frame_end = byte_end && (byte_q == LAST_BYTE);
  end

  // Next state: sync is honoured only while hunting; payload data never relocks
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (match || match_inv) state_d = PAYLOAD;
      PAYLOAD: if (frame_end)          state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // Counters, deserialiser and registered byte/pulse outputs
  always_comb begin
    sel_d   = sel_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    deser_d = deser_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (state_q == HUNT) begin
      if (match || match_inv) begin
        sel_d  = match_inv;
        bit_d  = 3'd0;
        byte_d = 8'd0;
      end
    end else begin
      deser_d = {deser_q[BYTE_W-2:0], dbit};
      bit_d   = bit_q + 3'd1;
      if (byte_end) begin
        data_d  = deser_d;
        valid_d = 1'b1;
        byte_d  = byte_q + 8'd1;
        done_d  = frame_end;
      end
    end
  end

  // Output drive; locked reflects the payload-collection state directly
  always_comb begin
    data_out   = data_q;
    data_valid = valid_q;
    frame_done = done_q;
    locked     = (state_q == PAYLOAD);
  end

  // State and datapath registers; reset discards any partial byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sel_q   <= 1'b0;
      bit_q   <= 3'd0;
      byte_q  <= 8'd0;
      deser_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      deser_q <= deser_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

endmodule
